dma8085: RTL

Synthesizable memory-to-memory block-copy master for the my8085 system bus. It takes bus ownership via the HOLD/HLDA handshake and copies LEN bytes from SRC_ADDR to DST_ADDR. The copy uses standard 8085 multiplexed memory-read and memory-write machine cycles (T1/T2/TW/T3) against the same memory responder the CPU uses. It sits beside my8085 on the shared ADDRDATA/ADDR bus; the top level merges its drivers with the CPU's using BUS_EN.

---
 rtl/dma8085_pkg.sv | 53 +++++
 rtl/dma8085_cycle.sv | 136 +++++++++++++
 rtl/dma8085.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dma8085_pkg.sv
// Shared types and bus constants for the dma8085 block-copy master.
// Exports the top-level phase, the T-state engine states and the combined debug state.
package dma8085_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_RT1, S_RT2, S_RTW, S_RT3,
        S_WT1, S_WT2, S_WTW, S_WT3, S_REL
    } state_t;

    typedef enum logic [2:0] {P_IDLE, P_REQ, P_RD, P_WR, P_REL} phase_t;

    typedef enum logic [2:0] {C_IDLE, C_T1, C_T2, C_TW, C_T3} tstate_t;

    localparam logic [1:0] MEM_RD   = 2'b10;
    localparam logic [1:0] MEM_WR   = 2'b01;
    localparam logic [1:0] BUS_IDLE = 2'b00;

    localparam logic IDLE_ALE   = 1'b0;
    localparam logic IDLE_RD_N  = 1'b1;
    localparam logic IDLE_WR_N  = 1'b1;
    localparam logic IDLE_IOM_N = 1'b1;

    // Folds the sequencing phase and the engine T-state into one observable state.
    function automatic state_t dbg_state(input phase_t p, input tstate_t t);
        state_t s;
        s = S_IDLE;
        case (p)
            P_REQ: s = S_REQ;
            P_REL: s = S_REL;
            P_RD: begin
                case (t)
                    C_T1:    s = S_RT1;
                    C_T2:    s = S_RT2;
                    C_TW:    s = S_RTW;
                    C_T3:    s = S_RT3;
                    default: s = S_IDLE;
                endcase
            end
            P_WR: begin
                case (t)
                    C_T1:    s = S_WT1;
                    C_T2:    s = S_WT2;
                    C_TW:    s = S_WTW;
                    C_T3:    s = S_WT3;
                    default: s = S_IDLE;
                endcase
            end
            default: s = S_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dma8085_cycle.sv
// Single 8085 memory machine-cycle engine (T1/T2/TW/T3); all bus outputs registered.
// Asserting i_go while in T3 chains the next cycle straight into T1.
module dma8085_cycle
    import dma8085_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_go,
    input  logic        i_wr,
    input  logic        i_abort,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_wdata,
    input  logic        i_ready,
    input  logic [7:0]  i_ad_in,
    output logic [7:0]  o_rdata,
    output logic        o_done,
    output tstate_t     o_tstate,
    output logic        o_bus_en,
    output logic [7:0]  o_addr_hi,
    output logic [7:0]  o_ad_out,
    output logic        o_ad_oe,
    output logic        o_ale,
    output logic        o_rd_n,
    output logic        o_wr_n,
    output logic        o_iom_n,
    output logic [1:0]  o_s1s0
);

    tstate_t     r_state;
    tstate_t     w_next;
    logic        r_wr;
    logic        w_wr;
    logic [7:0]  r_rdata;
    logic        r_bus_en;
    logic [7:0]  r_addr_hi;
    logic [7:0]  r_ad_out;
    logic        r_ad_oe;
    logic        r_ale;
    logic        r_rd_n;
    logic        r_wr_n;
    logic        r_iom_n;
    logic [1:0]  r_s1s0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            C_IDLE:      if (i_go) w_next = C_T1;
            C_T1:        w_next = C_T2;
            C_T2, C_TW:  w_next = i_ready ? C_T3 : C_TW;
            C_T3:        w_next = i_go ? C_T1 : C_IDLE;
            default:     w_next = C_IDLE;
        endcase
        if (i_abort) w_next = C_IDLE;
    end

    assign w_wr = (w_next == C_T1) ? i_wr : r_wr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= C_IDLE;
            r_wr    <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_state <= w_next;
            r_wr    <= w_wr;
            if (r_state == C_T3 && !r_wr) r_rdata <= i_ad_in;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bus_en  <= 1'b0;
            r_addr_hi <= 8'h00;
            r_ad_out  <= 8'h00;
            r_ad_oe   <= 1'b0;
            r_ale     <= IDLE_ALE;
            r_rd_n    <= IDLE_RD_N;
            r_wr_n    <= IDLE_WR_N;
            r_iom_n   <= IDLE_IOM_N;
            r_s1s0    <= BUS_IDLE;
        end else begin
            case (w_next)
                C_T1: begin
                    r_bus_en  <= 1'b1;
                    r_ale     <= 1'b1;
                    r_addr_hi <= i_addr[15:8];
                    r_ad_out  <= i_addr[7:0];
                    r_ad_oe   <= 1'b1;
                    r_rd_n    <= 1'b1;
                    r_wr_n    <= 1'b1;
                    r_iom_n   <= 1'b0;
                    r_s1s0    <= w_wr ? MEM_WR : MEM_RD;
                end
                C_T2, C_TW, C_T3: begin
                    r_bus_en <= 1'b1;
                    r_ale    <= 1'b0;
                    r_iom_n  <= 1'b0;
                    if (w_wr) begin
                        r_wr_n   <= 1'b0;
                        r_rd_n   <= 1'b1;
                        r_ad_oe  <= 1'b1;
                        r_ad_out <= i_wdata;
                    end else begin
                        r_rd_n  <= 1'b0;
                        r_wr_n  <= 1'b1;
                        r_ad_oe <= 1'b0;
                    end
                end
                default: begin
                    r_bus_en <= 1'b0;
                    r_ad_oe  <= 1'b0;
                    r_ale    <= IDLE_ALE;
                    r_rd_n   <= IDLE_RD_N;
                    r_wr_n   <= IDLE_WR_N;
                    r_iom_n  <= IDLE_IOM_N;
                    r_s1s0   <= BUS_IDLE;
                end
            endcase
        end
    end

    assign o_rdata   = r_rdata;
    assign o_done    = (r_state == C_T3);
    assign o_tstate  = r_state;
    assign o_bus_en  = r_bus_en;
    assign o_addr_hi = r_addr_hi;
    assign o_ad_out  = r_ad_out;
    assign o_ad_oe   = r_ad_oe;
    assign o_ale     = r_ale;
    assign o_rd_n    = r_rd_n;
    assign o_wr_n    = r_wr_n;
    assign o_iom_n   = r_iom_n;
    assign o_s1s0    = r_s1s0;

endmodule

// File: rtl/dma8085.sv
// Memory-to-memory block-copy bus master for the my8085 bus.
// Owns HOLD/HLDA sequencing, address/count registers and abort on lost grant.
module dma8085
    import dma8085_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_,
    input  logic        START,
    input  logic [15:0] SRC_ADDR,
    input  logic [15:0] DST_ADDR,
    input  logic [15:0] LEN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        HOLD,
    input  logic        HLDA,
    output logic        BUS_EN,
    output logic [7:0]  ADDR,
    output logic [7:0]  AD_OUT,
    output logic        AD_OE,
    input  logic [7:0]  AD_IN,
    output logic        ALE,
    output logic        RD_,
    output logic        WR_,
    output logic        IOM_,
    output logic        S1,
    output logic        S0,
    input  logic        READY,
    output state_t      DBG_STATE
);

    phase_t      r_phase;
    phase_t      w_phase;
    logic [15:0] r_src;
    logic [15:0] r_dst;
    logic [15:0] r_cnt;
    logic        r_hold;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        w_abort;
    logic        w_go;
    logic        w_wr;
    logic [15:0] w_addr;
    logic        w_cyc_done;
    logic [7:0]  w_rdata;
    tstate_t     w_tstate;
    logic [1:0]  w_s1s0;

    assign w_abort = (r_phase == P_RD || r_phase == P_WR) && !HLDA;

    always_comb begin
        w_phase = r_phase;
        w_go    = 1'b0;
        w_wr    = 1'b0;
        w_addr  = r_src;
        case (r_phase)
            P_IDLE: if (START && LEN != 16'h0000) w_phase = P_REQ;
            P_REQ: begin
                if (HLDA) begin
                    w_phase = P_RD;
                    w_go    = 1'b1;
                end
            end
            P_RD: begin
                if (w_abort) begin
                    w_phase = P_IDLE;
                end else if (w_cyc_done) begin
                    w_phase = P_WR;
                    w_go    = 1'b1;
                    w_wr    = 1'b1;
                    w_addr  = r_dst;
                end
            end
            P_WR: begin
                if (w_abort) begin
                    w_phase = P_IDLE;
                end else if (w_cyc_done) begin
                    if (r_cnt == 16'h0001) begin
                        w_phase = P_REL;
                    end else begin
                        w_phase = P_RD;
                        w_go    = 1'b1;
                        w_addr  = r_src + 16'h0001;
                    end
                end
            end
            P_REL:   if (!HLDA) w_phase = P_IDLE;
            default: w_phase = P_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            r_phase <= P_IDLE;
            r_src   <= 16'h0000;
            r_dst   <= 16'h0000;
            r_cnt   <= 16'h0000;
            r_hold  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_phase <= w_phase;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_phase)
                P_IDLE: begin
                    if (START) begin
                        if (LEN != 16'h0000) begin
                            r_src  <= SRC_ADDR;
                            r_dst  <= DST_ADDR;
                            r_cnt  <= LEN;
                            r_busy <= 1'b1;
                            r_hold <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                P_RD, P_WR: begin
                    if (w_abort) begin
                        r_hold <= 1'b0;
                        r_busy <= 1'b0;
                        r_err  <= 1'b1;
                    end else if (r_phase == P_WR && w_cyc_done) begin
                        // Addresses wrap modulo 2^16 by plain 16-bit overflow.
                        r_src <= r_src + 16'h0001;
                        r_dst <= r_dst + 16'h0001;
                        r_cnt <= r_cnt - 16'h0001;
                        if (r_cnt == 16'h0001) r_hold <= 1'b0;
                    end
                end
                P_REL: begin
                    if (!HLDA) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    dma8085_cycle u_cycle (
        .i_clk     (CLK),
        .i_rst_n   (RST_),
        .i_go      (w_go),
        .i_wr      (w_wr),
        .i_abort   (w_abort),
        .i_addr    (w_addr),
        .i_wdata   (w_rdata),
        .i_ready   (READY),
        .i_ad_in   (AD_IN),
        .o_rdata   (w_rdata),
        .o_done    (w_cyc_done),
        .o_tstate  (w_tstate),
        .o_bus_en  (BUS_EN),
        .o_addr_hi (ADDR),
        .o_ad_out  (AD_OUT),
        .o_ad_oe   (AD_OE),
        .o_ale     (ALE),
        .o_rd_n    (RD_),
        .o_wr_n    (WR_),
        .o_iom_n   (IOM_),
        .o_s1s0    (w_s1s0)
    );

    assign S1        = w_s1s0[1];
    assign S0        = w_s1s0[0];
    assign HOLD      = r_hold;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign ERR       = r_err;
    assign DBG_STATE = dbg_state(r_phase, w_tstate);

endmodule
